// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the flow-controlled UART transmitter.
//   - uart_tx_state_e : transmitter FSM states
//   - UART_DATA_W     : payload width of one UART character
//   - clks_per_bit()  : integer clocks per line bit for a clock/baud pair
//   - even_parity()   : even parity bit over one character
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO feeding the UART transmitter. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
// Read data is taken combinationally from the head entry; a written entry is
// visible one clock after the push (no fall-through).
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   push, wr_data: write request (ignored when full) and data
//   pop, rd_data : read request (ignored when empty) and head entry
//   full, empty  : occupancy flags
//   level        : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = (IDX_W + 1)'(1);

    logic [IDX_W:0]   wr_ptr_r;
    logic [IDX_W:0]   rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_s;
    logic             pop_s;

    assign push_s  = push && !full;
    assign pop_s   = pop && !empty;
    assign rd_data = mem_r[rd_ptr_r[IDX_W-1:0]];
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) &&
                     (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign level   = wr_ptr_r - rd_ptr_r;

    // Pointer update; reset discards all stored entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= (IDX_W + 1)'(0);
            rd_ptr_r <= (IDX_W + 1)'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fc.sv
// -----------------------------------------------------------------------------
// uart_tx_fc
// UART transmitter with a byte FIFO and RTS/CTS-style flow control. A new
// frame starts only while the host's active-low RTS (synchronised) is
// asserted; a frame already on the line always completes.
// Frames are 8N1 by default. Defining UART_TX_PARITY_EN inserts an even
// parity bit between the data bits and the stop bit (8E1).
// Ports:
//   clock   : platform clock
//   reset   : synchronous active-high reset
//   i_valid : byte offered; accepted when o_ready is high at the clock edge
//   i_data  : byte to send, LSB first
//   o_ready : FIFO can accept a byte this cycle
//   i_rtsn  : host RTS, active low, asynchronous
//   o_tx    : serial line, idle high (registered)
//   o_busy  : frame in progress or FIFO non-empty
//   o_level : FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_fc
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [UART_DATA_W-1:0]        i_data,
    output logic                          o_ready,
    input  logic                          i_rtsn,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);

    uart_tx_state_e               state_r;
    logic [BAUD_W-1:0]            baud_cnt_r;
    logic [2:0]                   bit_idx_r;
    logic [UART_DATA_W-1:0]       shift_r;
    logic                         tx_r;
    logic                         rts_sync1_r;
    logic                         rts_sync2_r;
    logic                         cts_s;
    logic                         ready_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         full_s;
    logic                         empty_s;
    logic [UART_DATA_W-1:0]       rd_data_s;
    logic [$clog2(FIFO_DEPTH):0]  level_s;
`ifdef UART_TX_PARITY_EN
    logic                         parity_r;
`endif

    assign cts_s   = !rts_sync2_r;
    assign ready_s = !full_s && !reset;
    assign push_s  = i_valid && ready_s;
    // Only IDLE consumes bytes, and only while the host allows sending.
    assign pop_s   = (state_r == IDLE) && !empty_s && cts_s && !reset;

    assign o_ready = ready_s;
    assign o_tx    = tx_r;
    assign o_level = level_s;
    assign o_busy  = (state_r != IDLE) || (|level_s);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push_s),
        .wr_data (i_data),
        .pop     (pop_s),
        .rd_data (rd_data_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level_s)
    );

    // Two-stage RTS synchroniser; resets to "host not ready".
    always_ff @(posedge clock) begin
        if (reset) begin
            rts_sync1_r <= 1'b1;
            rts_sync2_r <= 1'b1;
        end else begin
            rts_sync1_r <= i_rtsn;
            rts_sync2_r <= rts_sync1_r;
        end
    end

    // Frame sequencer: o_tx is loaded together with each state change so the
    // line level always matches the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= {UART_DATA_W{1'b0}};
            tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r    <= rd_data_s;
`ifdef UART_TX_PARITY_EN
                        parity_r   <= even_parity(rd_data_s);
`endif
                        baud_cnt_r <= BAUD_LOAD;
                        tx_r       <= 1'b0;
                        state_r    <= START;
                    end else begin
                        tx_r       <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt_r == BAUD_ZERO) begin
                        baud_cnt_r <= BAUD_LOAD;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == BAUD_ZERO) begin
                        baud_cnt_r <= BAUD_LOAD;
                        shift_r    <= {1'b0, shift_r[UART_DATA_W-1:1]};
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_r    <= parity_r;
                            state_r <= PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            // Next bit is shift_r[1] before this edge's shift.
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BAUD_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt_r == BAUD_ZERO) begin
                        baud_cnt_r <= BAUD_LOAD;
                        tx_r       <= 1'b1;
                        state_r    <= STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BAUD_ONE;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt_r == BAUD_ZERO) begin
                        tx_r    <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BAUD_ONE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fc.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fc
// Directed bench for uart_tx_fc at CLK_FREQ=1 MHz, BAUD=100 kHz (10 clocks
// per bit). Inputs change and outputs are sampled on the falling edge.
// "Cycle k" means the falling edge k clocks after a reference rising edge.
// Parity expectations follow UART_TX_PARITY_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_fc;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // IDLE-to-IDLE frame length in clocks.
    localparam int FRAME = NBITS * CPB + 1;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       i_rtsn  = 1'b0;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic [4:0] o_level;

    int checks = 0;
    int errors = 0;
    logic wave [0:1999];

    uart_tx_fc #(
        .CLK_FREQ   (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .i_rtsn  (i_rtsn),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_level (o_level)
    );

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        step(1);
        i_valid = 1'b0;
    endtask

    // Capture o_tx for n cycles; optionally change i_rtsn before sample tog_at.
    task automatic record(input int n, input int tog_at, input logic tog_val);
        for (int k = 0; k < n; k++) begin
            if (k == tog_at) i_rtsn = tog_val;
            wave[k] = o_tx;
            step(1);
        end
    endtask

    function automatic int find_start(input int from, input int to);
        for (int k = from; k < to; k++) begin
            if (wave[k] == 1'b0) return k;
        end
        return -1;
    endfunction

    // Mid-bit sampling of a frame whose first start-bit cycle is s.
    function automatic logic [7:0] decode(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = wave[s + CPB * (i + 1) + 5];
        return b;
    endfunction

    function automatic logic stop_bit(input int s);
        return wave[s + CPB * (NBITS - 1) + 5];
    endfunction

    // Expected line level k cycles after the push edge (pop at edge 1).
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        int idx;
        if (k < 1 || k > NBITS * CPB) return 1'b1;
        idx = (k - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx - 1];
        if (idx == 9 && NBITS == 11) return ^d;
        return 1'b1;
    endfunction

    initial begin
        logic [127:0] obs_v;
        logic [127:0] exp_v;
        logic         busy_hi;
        logic         busy_lo;
        logic         lvl1_c0;
        logic         lvl0_c1;
        logic         saw_low;

        // ---- reset state ----
        step(2);
        check("rst_tx", o_tx, 1'b1);
        check("rst_ready", o_ready, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_level", o_level, 5'd0);
        reset = 1'b0;
        step(1);
        check("ready_after_rst", o_ready, 1'b1);
        step(3);

        // ---- single byte 0x55, full waveform ----
        push_byte(8'h55);
        obs_v = '0;
        exp_v = '0;
        busy_hi = 1'b0; busy_lo = 1'b1; lvl1_c0 = 1'b0; lvl0_c1 = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            obs_v[k] = o_tx;
            exp_v[k] = exp_bit(8'h55, k);
            if (k == 0) lvl1_c0 = (o_level == 5'd1);
            if (k == 1) lvl0_c1 = (o_level == 5'd0);
            if (k == FRAME - 1) busy_hi = o_busy;
            if (k == FRAME) busy_lo = o_busy;
            step(1);
        end
        check("f55_wave", obs_v, exp_v);
        check("f55_level_push", lvl1_c0, 1'b1);
        check("f55_level_pop", lvl0_c1, 1'b1);
        check("f55_busy_last", busy_hi, 1'b1);
        check("f55_busy_fall", busy_lo, 1'b0);

        // ---- back-to-back 0xA3, 0x0F ----
        push_byte(8'hA3);
        push_byte(8'h0F);
        check("b2b_level", o_level, 5'd1);
        record(2 * FRAME + 10, -1, 1'b0);
        check("b2b_start1", find_start(0, 50), 0);
        check("b2b_byte1", decode(0), 8'hA3);
        check("b2b_stop1", stop_bit(0), 1'b1);
        check("b2b_start2", find_start(NBITS * CPB, 2 * FRAME + 10), FRAME);
        check("b2b_byte2", decode(FRAME), 8'h0F);
        check("b2b_stop2", stop_bit(FRAME), 1'b1);

        // ---- RTS held off, fill FIFO, drop the 17th, then release ----
        i_rtsn = 1'b1;
        step(3);
        saw_low = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(16 + i));
            if (o_tx == 1'b0) saw_low = 1'b1;
        end
        check("hold_level16", o_level, 5'd16);
        check("hold_ready0", o_ready, 1'b0);
        check("hold_line_idle", saw_low, 1'b0);
        push_byte(8'hEE);
        check("hold_drop17", o_level, 5'd16);
        check("hold_tx_high", o_tx, 1'b1);
        record(1700, 0, 1'b0);
        check("rel_first_start", find_start(0, 100), 3);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("rel_byte%0d", j), decode(3 + FRAME * j), 8'(16 + j));
        end
        check("rel_no_extra", find_start(3 + 16 * FRAME - 1, 1700), -1);
        check("rel_level0", o_level, 5'd0);
        check("rel_busy0", o_busy, 1'b0);

        // ---- RTS raised mid-DATA with two bytes queued ----
        push_byte(8'h3C);
        push_byte(8'hC5);
        record(300, 30, 1'b1);
        check("mid_start", find_start(0, 50), 0);
        check("mid_byte1", decode(0), 8'h3C);
        check("mid_stop1", stop_bit(0), 1'b1);
        check("mid_held", find_start(NBITS * CPB, 300), -1);
        check("mid_level1", o_level, 5'd1);
        record(FRAME + 10, 0, 1'b0);
        check("mid_resume_start", find_start(0, 50), 3);
        check("mid_byte2", decode(3), 8'hC5);

        // ---- reset during DATA bit 3 ----
        push_byte(8'h96);
        push_byte(8'h5A);
        step(44);
        check("rstm_bit3", o_tx, 1'b0);
        check("rstm_busy", o_busy, 1'b1);
        check("rstm_level", o_level, 5'd1);
        reset = 1'b1;
        step(1);
        check("rstm_tx", o_tx, 1'b1);
        check("rstm_level0", o_level, 5'd0);
        check("rstm_ready0", o_ready, 1'b0);
        reset = 1'b0;
        step(1);
        check("rstm_ready1", o_ready, 1'b1);
        record(30, -1, 1'b0);
        check("rstm_quiet", find_start(0, 30), -1);

`ifdef UART_TX_PARITY_EN
        // ---- parity bit values and 111-clock frame ----
        push_byte(8'h07);
        record(FRAME - 1, -1, 1'b0);
        check("par07_busy_last", o_busy, 1'b1);
        step(1);
        check("par07_busy_fall", o_busy, 1'b0);
        check("par07_byte", decode(1), 8'h07);
        check("par07_parity", wave[95], 1'b1);
        check("par07_stop", wave[105], 1'b1);
        push_byte(8'h03);
        record(FRAME - 1, -1, 1'b0);
        step(1);
        check("par03_byte", decode(1), 8'h03);
        check("par03_parity", wave[95], 1'b0);
        check("par03_stop", wave[105], 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
